uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2500: clk cycles per serial bit (50 us at 50 MHz); legal range 4..8191.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, LSB first; legal range 5..8.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial line; idle high; asynchronous to clk.
REQ-006 enable  input  1  when low, receiver holds IDLE and ignores rx.
REQ-007 data_out  output  DATA_BITS  last received byte; stable until the next valid frame.
REQ-008 data_valid  output  1  one-cycle pulse when a frame completes with a good stop bit.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value rx_s. Added latency: 2 cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE -> START SHALL occur when enable=1 and rx_s=0. The bit counter SHALL clear on that transition.
REQ-014 START: after CLKS_PER_BIT/2 cycles (integer division), rx_s is sampled.
  - 0 -> DATA, bit counter cleared.
  - 1 -> IDLE (glitch rejected); no output pulse.
REQ-015 DATA: every CLKS_PER_BIT cycles, rx_s is sampled into shift-register bit index (bits received so far).
  - After the DATA_BITS-th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, rx_s is sampled.
  - 1 -> data_out loaded from the shift register, data_valid=1 for one cycle, -> IDLE.
  - 0 -> frame_err=1 for one cycle, data_out unchanged, -> IDLE.
REQ-017 Returning to IDLE from STOP SHALL occur at the stop-bit midpoint, so back-to-back frames are accepted.
REQ-018 If enable falls mid-frame, the FSM SHALL go to IDLE on the next cycle with no pulse; data_out is unchanged.
REQ-019 After a frame_err, a line held low SHALL NOT start a new frame until rx_s has been seen high for at least 1 cycle in IDLE.
REQ-020 data_valid and frame_err SHALL never be high in the same cycle.
REQ-021 The bit timer SHALL be 13 bits wide and SHALL wrap only through an explicit clear; it never overflows within the legal parameter range.

Reset
REQ-022 While reset=1, all of the following SHALL hold immediately, independent of clk: FSM=IDLE, synchroniser flops=1, timer=0, bit counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse. The first frame SHALL be recognised no earlier than 3 cycles after reset deassertion.

Structure
REQ-024 The FSM state encoding and the default CLKS_PER_BIT SHALL live in a shared package uart_pkg, for reuse by the transmitter.
REQ-025 Bit timing SHALL be a sub-module baud_timer.
  - Inputs: clk, reset, clear, enable, and a 13-bit terminal count.
  - Output: one-cycle tick when count equals the terminal count; the count auto-clears on tick.
REQ-026 uart_rx SHALL contain only the synchroniser, FSM, bit counter, shift register and output registers.

Verification
REQ-027 CLKS_PER_BIT=16; send 0xA5 with a good stop bit -> exactly one data_valid pulse, data_out=0xA5, frame_err=0.
REQ-028 CLKS_PER_BIT=16; send 0x3C with stop bit=0 -> frame_err pulse, no data_valid, data_out keeps its previous value.
REQ-029 rx low pulse of 4 cycles at CLKS_PER_BIT=16 -> returns to IDLE at the start-bit midpoint; no pulses; busy falls.
REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses, 0x00 then 0xFF.
REQ-031 Reset asserted in the middle of DATA bit 4 -> all outputs 0 asynchronously; the next full frame 0x81 is received correctly.
REQ-032 Default CLKS_PER_BIT=2500; send 0x55 -> data_valid is asserted between 9.5*2500 and 9.5*2500+4 cycles after the start-bit falling edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period, timer width.
package uart_pkg;

  // Default clk cycles per serial bit: 50 us bit period from a 50 MHz clock.
  localparam int DEFAULT_CLKS_PER_BIT = 2500;

  // The bit timer is wide enough for the largest legal CLKS_PER_BIT (8191).
  localparam int TIMER_W = 13;

  // Bit counter width covers indices 0..7 for up to 8 data bits.
  localparam int BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/baud_timer.sv
// Free-running bit-period timer: pulses tick when the count reaches the
// terminal count, and restarts from zero on that same edge.
import uart_pkg::*;

module baud_timer (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] terminal,
  output logic               tick
);

  logic [TIMER_W-1:0] count;

  // Tick is combinational so the FSM acts on the same edge the count wraps.
  assign tick = enable && !clear && (count == terminal);

  // Count register: explicit clear, auto-clear on tick, otherwise increment.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, matching real hardware regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == terminal) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, IDLE/START/DATA/STOP FSM sampling at
// bit midpoints, LSB-first shift register and registered result pulses.
import uart_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  // Terminal counts: the start bit is checked half a bit in, every later
  // sample is one full bit after the previous one, landing on midpoints.
  localparam logic [TIMER_W-1:0] HALF_TC = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_TC  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_t          state, next_state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 tick;
  logic                 timer_clear;
  logic [TIMER_W-1:0]   terminal;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 wait_high;

  // Synchroniser: resets to the idle-high line level so reset cannot fake a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  baud_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (enable),
    .terminal (terminal),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; dropping enable aborts any frame back to IDLE.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (!rx_s && !wait_high)              next_state = START;
        START: if (tick)                             next_state = rx_s ? IDLE : DATA;
        DATA:  if (tick && bit_cnt == LAST_BIT)      next_state = STOP;
        STOP:  if (tick)                             next_state = IDLE;
        default:                                     next_state = IDLE;
      endcase
    end
  end

  // State-decoded outputs: busy flag and timer control.
  always_comb begin
    busy        = (state != IDLE);
    timer_clear = (state == IDLE) || !enable;
    terminal    = (state == START) ? HALF_TC : BIT_TC;
  end

  // Datapath: bit counter, shift register, result registers, relock flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      wait_high  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE && next_state == START) bit_cnt <= '0;
      if (state == START && next_state == DATA) bit_cnt <= '0;
      if (enable && tick && state == DATA) begin
        shift_reg[bit_cnt] <= rx_s;
        bit_cnt            <= bit_cnt + 1'b1;
      end
      if (enable && tick && state == STOP) begin
        if (rx_s) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
          wait_high  <= 1'b1;
        end
      end
      // A broken frame leaves the line suspect: re-arm only after seeing it high.
      if (state == IDLE && rx_s) wait_high <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one fast instance (16 clks/bit) for function,
// one default instance (2500 clks/bit) for end-to-end latency.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, busy;

  logic       rx_def = 1'b1;
  logic [7:0] data_out_def;
  logic       data_valid_def, frame_err_def, busy_def;

  int checks = 0;
  int errors = 0;

  int        valid_cnt = 0;
  int        err_cnt = 0;
  int        both_cnt = 0;
  logic [7:0] valid_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .enable(enable),
    .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy)
  );

  uart_rx dut_def (
    .clk(clk), .reset(reset), .rx(rx_def), .enable(1'b1),
    .data_out(data_out_def), .data_valid(data_valid_def),
    .frame_err(frame_err_def), .busy(busy_def)
  );

  // Pulse monitor for the fast instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        valid_cnt++;
        valid_q.push_back(data_out);
      end
      if (frame_err) err_cnt++;
      if (data_valid && frame_err) both_cnt++;
    end
  end

  task automatic clear_monitor();
    valid_cnt = 0;
    err_cnt   = 0;
    valid_q.delete();
  endtask

  // Hold rx at val for n bit periods, changing just after a rising edge.
  task automatic drive_bit(input logic val, input int n);
    @(posedge clk);
    #1 rx = val;
    repeat (n * CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 1);
    drive_bit(stop_bit, 1);
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b want 00/0/0/0", data_out, data_valid, frame_err, busy);
    end
    checks++;
    if ({data_out_def, data_valid_def, frame_err_def, busy_def} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs_def: got %h/%b/%b/%b want 00/0/0/0",
               data_out_def, data_valid_def, frame_err_def, busy_def);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_good_frame();
    clear_monitor();
    send_frame(8'hA5, 1'b1);
    idle_cycles(20);
    @(negedge clk);
    checks++;
    if (valid_cnt !== 1 || err_cnt !== 0) begin
      errors++;
      $display("FAIL good_pulses: valid=%0d err=%0d want valid=1 err=0", valid_cnt, err_cnt);
    end
    checks++;
    if (data_out !== 8'hA5 || valid_q.size() != 1 || valid_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL good_data: data_out=%h want a5", data_out);
    end
  endtask

  task automatic test_frame_err();
    int busy_n = 0;
    clear_monitor();
    send_frame(8'h3C, 1'b0);
    // Line stays low after the bad stop bit: no new frame may start.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    checks++;
    if (err_cnt !== 1 || valid_cnt !== 0) begin
      errors++;
      $display("FAIL ferr_pulses: valid=%0d err=%0d want valid=0 err=1", valid_cnt, err_cnt);
    end
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_data_hold: data_out=%h want a5", data_out);
    end
    checks++;
    if (busy_n !== 0) begin
      errors++;
      $display("FAIL ferr_low_line_restart: busy cycles=%0d want 0", busy_n);
    end
    idle_cycles(10);
    clear_monitor();
    send_frame(8'h96, 1'b1);
    idle_cycles(20);
    checks++;
    if (valid_cnt !== 1 || data_out !== 8'h96) begin
      errors++;
      $display("FAIL ferr_recover: valid=%0d data_out=%h want 1/96", valid_cnt, data_out);
    end
  endtask

  task automatic test_glitch();
    int busy_n = 0;
    clear_monitor();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 rx = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) busy_n++;
    end
    checks++;
    if (busy_n !== CPB / 2) begin
      errors++;
      $display("FAIL glitch_busy_len: busy cycles=%0d want %0d", busy_n, CPB / 2);
    end
    checks++;
    if (busy !== 1'b0 || valid_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b valid=%0d err=%0d want 0/0/0", busy, valid_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_monitor();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_cycles(20);
    checks++;
    if (valid_cnt !== 2 || err_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_pulses: valid=%0d err=%0d want 2/0", valid_cnt, err_cnt);
    end else begin
      checks++;
      if (valid_q[0] !== 8'h00 || valid_q[1] !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_data: got %h,%h want 00,ff", valid_q[0], valid_q[1]);
      end
    end
  endtask

  task automatic test_enable_drop();
    int busy_n = 0;
    clear_monitor();
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 2);
    @(posedge clk);
    #1 enable = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_abort: busy=%b want 0", busy);
    end
    @(posedge clk);
    #1 enable = 1'b1;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    checks++;
    if (valid_cnt !== 0 || err_cnt !== 0 || busy_n !== 0 || data_out !== 8'hFF) begin
      errors++;
      $display("FAIL enable_no_pulse: valid=%0d err=%0d busy=%0d data_out=%h want 0/0/0/ff",
               valid_cnt, err_cnt, busy_n, data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h5A;
    clear_monitor();
    drive_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1);
    @(posedge clk);
    #1 rx = d[4];
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, busy} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b/%b want 00/0/0/0", data_out, data_valid, frame_err, busy);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    send_frame(8'h81, 1'b1);
    idle_cycles(20);
    checks++;
    if (valid_cnt !== 1 || err_cnt !== 0 || data_out !== 8'h81) begin
      errors++;
      $display("FAIL post_reset_frame: valid=%0d err=%0d data_out=%h want 1/0/81", valid_cnt, err_cnt, data_out);
    end
  endtask

  task automatic test_default_timing();
    logic [7:0] d = 8'h55;
    logic [9:0] bits;
    int cycles = 0;
    bit seen = 0;
    bits = {1'b1, d, 1'b0};
    @(posedge clk);
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          #1 rx_def = bits[b];
          repeat (2500) @(posedge clk);
        end
        #1 rx_def = 1'b1;
      end
      begin
        while (!seen && cycles < 30000) begin
          @(posedge clk);
          cycles++;
          #2 if (data_valid_def) seen = 1;
        end
      end
    join
    checks++;
    if (!seen || cycles < 23750 || cycles > 23754) begin
      errors++;
      $display("FAIL default_latency: seen=%0d cycles=%0d want 23750..23754", seen, cycles);
    end
    checks++;
    if (data_out_def !== 8'h55 || frame_err_def !== 1'b0) begin
      errors++;
      $display("FAIL default_data: data_out=%h ferr=%b want 55/0", data_out_def, frame_err_def);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_good_frame();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
    test_default_timing();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL exclusive_pulses: overlap cycles=%0d want 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
